pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and fetch-sequencing stage for the piRISC core. It sits directly downstream of the branch `comparator`. It consumes the taken/not-taken result together with the EX-stage target operands, holds the architectural fetch PC, and issues one word-aligned fetch request per cycle to instruction memory. On a taken branch or jump it redirects the PC and flushes the wrong-path instruction in IF/ID.

## Interface
- `VAR_WIDTH`, 32: datapath and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hazard hold; freezes the PC while no redirect is pending.
- `branch`  in  1  EX instruction is a conditional branch.
- `comparator`  in  1  branch condition true (from `comparator`).
- `jump`  in  1  EX instruction is JAL or JALR.
- `jalr`  in  1  with `jump`, selects the register-relative target.
- `ex_pc`  in  VAR_WIDTH  PC of the EX instruction.
- `imm`  in  VAR_WIDTH  sign-extended offset.
- `rs1`  in  VAR_WIDTH  JALR base register value.
- `imem_ack`  in  1  instruction memory accepted the current request.
- `pc`  out  VAR_WIDTH  current fetch address.
- `pc_plus4`  out  VAR_WIDTH  `pc + 4`, combinational.
- `fetch_req`  out  1  fetch request valid.
- `flush`  out  1  kill the IF/ID instruction this cycle.
- `misaligned`  out  1  target-misaligned trap pulse (see Configuration).

## Operation
- Redirect condition: `take = (branch & comparator) | jump`, evaluated in RUN only.
- Branch target:
  - JALR: `(rs1 + imm) & ~1`.
  - Otherwise: `ex_pc + imm`.
  - All additions are modulo 2^VAR_WIDTH; wrap-around is silent.
- FSM states: BOOT, RUN, REDIRECT, HALT.
  - BOOT: `fetch_req=0`. Goes to RUN on the next edge.
  - RUN: `fetch_req=1`.
    - If `take`: `pc<=target`, `flush=1` in the same cycle, go to REDIRECT.
    - Else if `imem_ack & ~stall`: `pc<=pc+4`.
    - Otherwise: PC holds.
  - REDIRECT: one bubble cycle; `fetch_req=0`, `flush=0`, PC holds. Goes to RUN.
  - HALT: entered only with the macro on. `fetch_req=0`; the block stays here until `rst`.
- Priorities and simultaneous events:
  - `take` beats `stall` and `imem_ack`; an outstanding unacknowledged fetch is abandoned.
  - `branch=1` with `comparator=0` and `jump=0` means no redirect.
  - `take` asserted in BOOT or REDIRECT is ignored. The upstream stage must hold EX until RUN.
  - `stall` with no ack holds the PC, and `fetch_req` stays high.
- `flush` is combinational from registered state and current inputs; it is never asserted outside RUN.

## Timing
- Values forced while `rst` is asserted (asynchronously): `pc=RESET_PC`, state BOOT, `fetch_req=0`, `flush=0`, `misaligned=0`.
- Reset asserted mid-operation discards any pending redirect or fetch immediately.
- First request: `fetch_req` rises one edge after `rst` deasserts, with `pc=RESET_PC`.
- Sequential advance: one word per cycle when `imem_ack=1` each cycle.
- Redirect latency:
  - `take` in cycle N → `pc=target` from edge N+1.
  - Bubble in cycle N+1.
  - `fetch_req=1` at the target from cycle N+2.

## Configuration
- Macro `PC_MISALIGN_TRAP_EN`.
- Defined:
  - If `take` and `target[1:0]!=0`, the redirect is suppressed and the PC holds.
  - `flush=1` in that cycle.
  - `misaligned` is registered high for exactly one cycle after the edge, then the FSM enters HALT.
- Undefined:
  - `target[1:0]` is forced to 2'b00 before loading.
  - `misaligned` is tied to 0.
  - HALT is unreachable.

## Test plan
- Reset/boot: `RESET_PC=32'h100`, release `rst`, `imem_ack=1` → `fetch_req` high one cycle later; `pc` goes 0x100, 0x104, 0x108 on consecutive cycles.
- Stall and no-ack: `stall=1` for 3 cycles at `pc=0x108`, then `imem_ack=0` for 2 cycles → `pc` stays 0x108 throughout, `fetch_req` stays high.
- Taken branch beats stall: `branch=1`, `comparator=1`, `stall=1`, `ex_pc=0x200`, `imm=-8` → `flush=1` that cycle; `pc=0x1F8` next; one cycle with `fetch_req=0`; then fetch at 0x1F8.
- Not-taken branch: `branch=1`, `comparator=0` → no flush, `pc` increments by 4.
- JALR: `rs1=0x3001`, `imm=4` → `pc=0x3004` (LSB cleared). With `ex_pc=0xFFFF_FFFC`, `imm=8` (non-JALR) → `pc=0x4` (wrap).
- Misaligned target: `jump=1`, `jalr=0`, `ex_pc=0x10`, `imm=6` → macro on: `flush=1`, one-cycle `misaligned` pulse, PC holds 0x...; FSM in HALT with `fetch_req=0` until `rst`. Macro off: `pc=0x14`, `misaligned=0`.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-stage bundle: branch resolution and hazard inputs toward pc_unit, fetch address/flush/trap back out.
// master = upstream driver (EX stage / bench), slave = pc_unit.
interface pc_unit_if #(
  parameter int VAR_WIDTH = 32
);
  logic                 stall;
  logic                 branch;
  logic                 comparator;
  logic                 jump;
  logic                 jalr;
  logic [VAR_WIDTH-1:0] ex_pc;
  logic [VAR_WIDTH-1:0] imm;
  logic [VAR_WIDTH-1:0] rs1;
  logic                 imem_ack;
  logic [VAR_WIDTH-1:0] pc;
  logic [VAR_WIDTH-1:0] pc_plus4;
  logic                 fetch_req;
  logic                 flush;
  logic                 misaligned;

  modport master (
    output stall, branch, comparator, jump, jalr, ex_pc, imm, rs1, imem_ack,
    input  pc, pc_plus4, fetch_req, flush, misaligned
  );

  modport slave (
    input  stall, branch, comparator, jump, jalr, ex_pc, imm, rs1, imem_ack,
    output pc, pc_plus4, fetch_req, flush, misaligned
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC sequencer with branch/jump redirect; PC_MISALIGN_TRAP_EN traps misaligned targets into HALT.
// Latency: redirect loads the PC on the next edge, followed by one bubble cycle without a fetch request.
// Backpressure: PC advances only on imem_ack with no stall; a taken redirect overrides both.
module pc_unit #(
  parameter int                   VAR_WIDTH = 32,
  parameter logic [VAR_WIDTH-1:0] RESET_PC  = '0
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALT} state_t;

  localparam logic [VAR_WIDTH-1:0] LSB_MASK  = ~VAR_WIDTH'(1);
  localparam logic [VAR_WIDTH-1:0] WORD_MASK = ~VAR_WIDTH'(3);

  state_t               state, state_nxt;
  logic [VAR_WIDTH-1:0] pc_q, pc_nxt;
  logic [VAR_WIDTH-1:0] target_raw, target;
  logic                 bad_target;
  logic                 take;
  logic                 flush;
  logic                 fetch_req;
  logic                 mis_q, mis_nxt;

  always_comb begin
    if (bus.jump && bus.jalr) target_raw = (bus.rs1 + bus.imm) & LSB_MASK;
    else                      target_raw = bus.ex_pc + bus.imm;
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign bad_target = |target_raw[1:0];
  assign target     = target_raw;
`else
  // Without the trap, misaligned targets are silently word-aligned.
  assign bad_target = 1'b0;
  assign target     = target_raw & WORD_MASK;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    mis_nxt   = 1'b0;
    take      = 1'b0;
    flush     = 1'b0;
    fetch_req = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        fetch_req = 1'b1;
        take      = (bus.branch & bus.comparator) | bus.jump;
        if (take) begin
          flush = 1'b1;
          if (bad_target) begin
            mis_nxt   = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt    = target;
            state_nxt = REDIRECT;
          end
        end else if (bus.imem_ack && !bus.stall) begin
          pc_nxt = pc_q + VAR_WIDTH'(4);
        end
      end
      REDIRECT: state_nxt = RUN;
      HALT:     state_nxt = HALT;
      default:  state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      mis_q <= mis_nxt;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + VAR_WIDTH'(4);
  assign bus.fetch_req  = fetch_req;
  assign bus.flush      = flush;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a behavioural PC model.
module tb_pc_unit;
  localparam int          W      = 32;
  localparam logic [31:0] RST_PC = 32'h100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_unit_if #(.VAR_WIDTH(W)) bus ();
  pc_unit #(.VAR_WIDTH(W), .RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Behavioural model: fetch address plus "what kind of cycle is this" flags.
  logic [31:0] m_pc;
  bit m_started, m_bubble, m_halt, m_mis;

  function automatic logic [31:0] ref_target();
    logic [31:0] t;
    if (bus.jump && bus.jalr) begin
      t = bus.rs1 + bus.imm;
      t[0] = 1'b0;
    end else begin
      t = bus.ex_pc + bus.imm;
    end
    return t;
  endfunction

  function automatic bit m_running();
    return m_started && !m_bubble && !m_halt;
  endfunction

  function automatic bit m_take();
    return m_running() && ((bus.branch && bus.comparator) || bus.jump);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_started = 0; m_bubble = 0; m_halt = 0; m_mis = 0;
  endtask

  task automatic tick();
    logic [31:0] t;
    bit mis_n = 0;
    if (!rst) begin
      if (!m_started) m_started = 1;
      else if (m_take()) begin
        t = ref_target();
        if (TRAP && t[1:0] != 2'b00) begin
          m_halt = 1; mis_n = 1;
        end else begin
          m_pc = t & 32'hFFFF_FFFC; m_bubble = 1;
        end
      end else if (m_running()) begin
        if (bus.imem_ack && !bus.stall) m_pc = m_pc + 32'd4;
      end else if (m_bubble) m_bubble = 0;
      m_mis = mis_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, b, c, j, jr, input logic [31:0] ep, im, r1, input logic ack);
    bus.stall = s; bus.branch = b; bus.comparator = c; bus.jump = j; bus.jalr = jr;
    bus.ex_pc = ep; bus.imm = im; bus.rs1 = r1; bus.imem_ack = ack;
  endtask

  task automatic test_reset();
    set_in(0, 1, 1, 1, 0, 32'h0, 32'h40, 32'h0, 1);
    rst = 1'b1;
    model_reset();
    #1;
    tests++; if (bus.pc !== RST_PC) begin fails++; $display("FAIL reset_pc got %h exp %h", bus.pc, RST_PC); end
    tests++; if ({bus.fetch_req, bus.flush, bus.misaligned} !== 3'b000) begin fails++;
      $display("FAIL reset_outs got %b exp 000", {bus.fetch_req, bus.flush, bus.misaligned}); end
    tests++; if (bus.pc_plus4 !== RST_PC + 32'd4) begin fails++; $display("FAIL reset_pc_plus4 got %h exp %h", bus.pc_plus4, RST_PC + 32'd4); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    #1;
    tests++; if ({bus.fetch_req, bus.flush} !== 2'b00) begin fails++; $display("FAIL boot_idle got %b exp 00", {bus.fetch_req, bus.flush}); end
    tick();
    tests++; if (bus.fetch_req !== 1'b1 || bus.pc !== RST_PC) begin fails++;
      $display("FAIL first_fetch got req=%b pc=%h exp req=1 pc=%h", bus.fetch_req, bus.pc, RST_PC); end
  endtask

  task automatic test_sequential();
    tick();
    tests++; if (bus.pc !== 32'h104) begin fails++; $display("FAIL seq_104 got %h exp 104", bus.pc); end
    tick();
    tests++; if (bus.pc !== 32'h108 || bus.pc_plus4 !== 32'h10C) begin fails++;
      $display("FAIL seq_108 got %h/%h exp 108/10c", bus.pc, bus.pc_plus4); end
  endtask

  task automatic test_stall();
    set_in(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      #1;
      tests++; if (bus.pc !== 32'h108 || bus.fetch_req !== 1'b1) begin fails++;
        $display("FAIL stall_hold[%0d] got pc=%h req=%b exp pc=108 req=1", i, bus.pc, bus.fetch_req); end
      tick();
    end
    tests++; if (bus.pc !== 32'h108) begin fails++; $display("FAIL stall_end got %h exp 108", bus.pc); end
  endtask

  task automatic test_branch_beats_stall();
    set_in(1, 1, 1, 0, 0, 32'h200, 32'hFFFF_FFF8, 32'h0, 0);
    #1;
    tests++; if (bus.flush !== 1'b1) begin fails++; $display("FAIL br_flush got %b exp 1", bus.flush); end
    tick();
    // Redirect during the bubble must be ignored.
    set_in(0, 0, 0, 1, 0, 32'h0, 32'h40, 32'h0, 1);
    #1;
    tests++; if (bus.pc !== 32'h1F8 || bus.fetch_req !== 1'b0 || bus.flush !== 1'b0) begin fails++;
      $display("FAIL br_bubble got pc=%h req=%b fl=%b exp pc=1f8 req=0 fl=0", bus.pc, bus.fetch_req, bus.flush); end
    tick();
    set_in(0, 1, 0, 0, 0, 32'h0, 32'h40, 32'h0, 1);
    #1;
    tests++; if (bus.pc !== 32'h1F8 || bus.fetch_req !== 1'b1) begin fails++;
      $display("FAIL br_refetch got pc=%h req=%b exp pc=1f8 req=1", bus.pc, bus.fetch_req); end
  endtask

  task automatic test_not_taken();
    tests++; if (bus.flush !== 1'b0) begin fails++; $display("FAIL nt_flush got %b exp 0", bus.flush); end
    tick();
    tests++; if (bus.pc !== 32'h1FC) begin fails++; $display("FAIL nt_pc got %h exp 1fc", bus.pc); end
  endtask

  task automatic test_jalr();
    set_in(0, 0, 0, 1, 1, 32'h0, 32'h4, 32'h3001, 1);
    tick();
    tests++; if (bus.pc !== 32'h3004) begin fails++; $display("FAIL jalr_pc got %h exp 3004", bus.pc); end
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    tick();
    set_in(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1);
    tick();
    tests++; if (bus.pc !== 32'h4) begin fails++; $display("FAIL jal_wrap got %h exp 4", bus.pc); end
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    tick();
  endtask

  task automatic test_misaligned();
    set_in(0, 0, 0, 1, 0, 32'h10, 32'h6, 32'h0, 1);
    #1;
    tests++; if (bus.flush !== 1'b1) begin fails++; $display("FAIL mis_flush got %b exp 1", bus.flush); end
    tick();
    if (TRAP) begin
      tests++; if (bus.pc !== 32'h4 || bus.misaligned !== 1'b1 || bus.fetch_req !== 1'b0) begin fails++;
        $display("FAIL mis_trap got pc=%h mis=%b req=%b exp pc=4 mis=1 req=0", bus.pc, bus.misaligned, bus.fetch_req); end
      tick();
      tests++; if (bus.misaligned !== 1'b0 || bus.fetch_req !== 1'b0) begin fails++;
        $display("FAIL mis_halt got mis=%b req=%b exp 0 0", bus.misaligned, bus.fetch_req); end
      tick();
      tests++; if (bus.fetch_req !== 1'b0 || bus.flush !== 1'b0 || bus.pc !== 32'h4) begin fails++;
        $display("FAIL mis_halt_stays got req=%b fl=%b pc=%h exp 0 0 4", bus.fetch_req, bus.flush, bus.pc); end
    end else begin
      tests++; if (bus.pc !== 32'h14 || bus.misaligned !== 1'b0) begin fails++;
        $display("FAIL mis_align got pc=%h mis=%b exp pc=14 mis=0", bus.pc, bus.misaligned); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; model_reset(); #1; rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    tick(); tick();
    set_in(0, 0, 0, 1, 0, 32'h800, 32'h20, 32'h0, 1);
    #2;
    rst = 1'b1; model_reset();
    #1;
    tests++; if (bus.pc !== RST_PC || bus.fetch_req !== 1'b0 || bus.flush !== 1'b0) begin fails++;
      $display("FAIL mid_reset got pc=%h req=%b fl=%b exp pc=%h 0 0", bus.pc, bus.fetch_req, bus.flush, RST_PC); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (bus.pc !== RST_PC || bus.fetch_req !== 1'b0) begin fails++;
      $display("FAIL mid_reset_boot got pc=%h req=%b exp pc=%h req=0", bus.pc, bus.fetch_req, RST_PC); end
  endtask

  task automatic test_random();
    logic [31:0] im;
    int halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0 || halt_cycles > 3) begin
        rst = 1'b1; model_reset(); #1;
        tests++; if (bus.pc !== RST_PC || bus.fetch_req !== 1'b0) begin fails++;
          $display("FAIL rnd_reset[%0d] got pc=%h req=%b", i, bus.pc, bus.fetch_req); end
        rst = 1'b0;
        halt_cycles = 0;
      end
      im = ($urandom_range(0, 255) << 2) - 32'd512;
      if ($urandom_range(0, 5) == 0) im = im | 32'($urandom_range(1, 3));
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
             $urandom & 32'hFFFF_FFFC, im, $urandom, $urandom_range(0, 3) != 0);
      #1;
      tests++; if (bus.pc !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin fails++;
        $display("FAIL rnd_pc[%0d] got %h/%h exp %h", i, bus.pc, bus.pc_plus4, m_pc); end
      tests++; if (bus.fetch_req !== m_running()) begin fails++;
        $display("FAIL rnd_req[%0d] got %b exp %b", i, bus.fetch_req, m_running()); end
      tests++; if (bus.flush !== m_take()) begin fails++;
        $display("FAIL rnd_flush[%0d] got %b exp %b", i, bus.flush, m_take()); end
      tests++; if (bus.misaligned !== m_mis) begin fails++;
        $display("FAIL rnd_mis[%0d] got %b exp %b", i, bus.misaligned, m_mis); end
      if (m_halt) halt_cycles++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_beats_stall();
    test_not_taken();
    test_jalr();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
